// File: rtl/falafel_pkg.sv
// Shared word width and type for the falafel memory controller and its storage.
package falafel_pkg;

    localparam int DATA_W     = 64;
    localparam int BYTE_OFF_W = $clog2(DATA_W / 8);

    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/falafel_sram_1rw.sv
// Single-port DEPTH x DATA_W storage with synchronous read; no reset on contents.
module falafel_sram_1rw
    import falafel_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  word_t         wdata_i,
    output word_t         rdata_o
);

    word_t mem [DEPTH];
    word_t rdata_q;

    // A write leaves the read register untouched, so earlier read data survives it.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end else if (re_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/falafel_mem_ctrl.sv
// Word-addressed memory controller with write, read and compare-and-swap operations.
// Optional macro FALAFEL_MEM_BOUNDS_EN enables out-of-range detection and sticky err_o.
module falafel_mem_ctrl
    import falafel_pkg::*;
#(
    parameter int    DEPTH     = 1024,
    parameter word_t BASE_ADDR = '0
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  mem_req_val_i,
    output logic  mem_req_ack_o,
    input  logic  mem_req_is_write_i,
    input  logic  mem_req_is_cas_i,
    input  word_t mem_req_addr_i,
    input  word_t mem_req_data_i,
    input  word_t mem_req_cas_exp_i,
    output logic  mem_resp_val_o,
    input  logic  mem_resp_rdy_i,
    output word_t mem_resp_data_o,
    output logic  err_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RD, CAS, RESP} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    word_t           data_q, data_d;
    word_t           exp_q, exp_d;
    logic            oob_q, oob_d;
    word_t           resp_data_q, resp_data_d;

    word_t           req_off;
    logic [AW-1:0]   req_idx;
    logic            req_oob;

    logic            sram_we;
    logic            sram_re;
    logic [AW-1:0]   sram_addr;
    word_t           sram_wdata;
    word_t           sram_rdata;

    assign req_off = mem_req_addr_i - BASE_ADDR;
    // Truncation to AW bits gives the modulo-DEPTH wrap when bounds checking is off.
    assign req_idx = AW'(req_off >> BYTE_OFF_W);

`ifdef FALAFEL_MEM_BOUNDS_EN
    assign req_oob = (mem_req_addr_i < BASE_ADDR) ||
                     ((req_off >> BYTE_OFF_W) >= word_t'(DEPTH));
`else
    assign req_oob = 1'b0;
`endif

    assign mem_req_ack_o   = rst_ni && (state_q == IDLE) && mem_req_val_i;
    assign mem_resp_val_o  = (state_q == RESP);
    assign mem_resp_data_o = resp_data_q;

    // Reads and CAS issue the array read on the accept edge, so the old value is
    // already visible during RD/CAS and the CAS compare/write fits in one cycle.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        data_d      = data_q;
        exp_d       = exp_q;
        oob_d       = oob_q;
        resp_data_d = resp_data_q;
        sram_we     = 1'b0;
        sram_re     = 1'b0;
        sram_addr   = req_idx;
        sram_wdata  = mem_req_data_i;

        case (state_q)
            IDLE: begin
                if (mem_req_ack_o) begin
                    idx_d  = req_idx;
                    data_d = mem_req_data_i;
                    exp_d  = mem_req_cas_exp_i;
                    oob_d  = req_oob;
                    if (mem_req_is_write_i && !mem_req_is_cas_i) begin
                        sram_we = !req_oob;
                    end else begin
                        sram_re = !req_oob;
                        state_d = mem_req_is_write_i ? CAS : RD;
                    end
                end
            end
            RD: begin
                resp_data_d = oob_q ? '1 : sram_rdata;
                state_d     = RESP;
            end
            CAS: begin
                resp_data_d = oob_q ? '1 : sram_rdata;
                sram_addr   = idx_q;
                sram_wdata  = data_q;
                sram_we     = !oob_q && (sram_rdata == exp_q);
                state_d     = RESP;
            end
            RESP: begin
                if (mem_resp_rdy_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            data_q      <= '0;
            exp_q       <= '0;
            oob_q       <= 1'b0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            exp_q       <= exp_d;
            oob_q       <= oob_d;
            resp_data_q <= resp_data_d;
        end
    end

`ifdef FALAFEL_MEM_BOUNDS_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (mem_req_ack_o & req_oob);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    falafel_sram_1rw #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk_i   (clk_i),
        .we_i    (sram_we),
        .re_i    (sram_re),
        .addr_i  (sram_addr),
        .wdata_i (sram_wdata),
        .rdata_o (sram_rdata)
    );

endmodule

// File: tb/tb_falafel_mem_ctrl.sv
// Randomized self-checking bench for falafel_mem_ctrl against a word-array reference model.
module tb_falafel_mem_ctrl;

    localparam int          DEPTH = 1024;
    localparam logic [63:0] BASE  = 64'h1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_val;
    logic        req_ack;
    logic        req_w;
    logic        req_c;
    logic [63:0] req_addr;
    logic [63:0] req_data;
    logic [63:0] req_exp;
    logic        resp_val;
    logic        resp_rdy;
    logic [63:0] resp_data;
    logic        err;

    int          n_cmp = 0;
    int          n_bad = 0;

    logic [63:0] model_mem [DEPTH];
    bit          model_err = 1'b0;

    always #5 clk = ~clk;

    falafel_mem_ctrl #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .mem_req_val_i      (req_val),
        .mem_req_ack_o      (req_ack),
        .mem_req_is_write_i (req_w),
        .mem_req_is_cas_i   (req_c),
        .mem_req_addr_i     (req_addr),
        .mem_req_data_i     (req_data),
        .mem_req_cas_exp_i  (req_exp),
        .mem_resp_val_o     (resp_val),
        .mem_resp_rdy_i     (resp_rdy),
        .mem_resp_data_o    (resp_data),
        .err_o              (err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: the memory is an array of words; an operation's result follows
    // directly from the word index derived from the byte address.
    function automatic logic [63:0] model_op(input bit w, input bit c, input logic [63:0] addr,
                                             input logic [63:0] data, input logic [63:0] exp);
        logic [63:0] widx;
        logic [63:0] old;
        int          idx;
        widx = (addr - BASE) / 8;
`ifdef FALAFEL_MEM_BOUNDS_EN
        if (addr < BASE || widx >= 64'(DEPTH)) begin
            model_err = 1'b1;
            return '1;
        end
`endif
        idx = int'(widx % 64'(DEPTH));
        old = model_mem[idx];
        if (w && !c) begin
            model_mem[idx] = data;
            return '0;
        end
        if (w && c && old == exp) model_mem[idx] = data;
        return old;
    endfunction

    task automatic scramble();
        req_w    = 1'($urandom);
        req_c    = 1'($urandom);
        req_addr = {$urandom, $urandom};
        req_data = {$urandom, $urandom};
        req_exp  = {$urandom, $urandom};
    endtask

    // Called and returns at posedge+1.
    task automatic do_op(input bit w, input bit c, input logic [63:0] addr, input logic [63:0] data,
                         input logic [63:0] exp, input int dly, output logic [63:0] got);
        int n;
        got      = '0;
        req_w    = w;
        req_c    = c;
        req_addr = addr;
        req_data = data;
        req_exp  = exp;
        req_val  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ack", 64'(req_ack), 64'd1);
        if (!req_ack) begin
            req_val = 1'b0;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        req_val = 1'b0;
        scramble();
        if (w && !c) begin
            chk("wr_noresp", 64'(resp_val), 64'd0);
            $display("op WR  addr=%h data=%h", addr, data);
            return;
        end
        chk("busy_noval", 64'(resp_val), 64'd0);
        @(posedge clk); #1;
        chk("resp_val", 64'(resp_val), 64'd1);
        got = resp_data;
        for (int i = 0; i < dly; i++) begin
            @(posedge clk); #1;
            chk("hold_val", 64'(resp_val), 64'd1);
            chk("hold_data", resp_data, got);
        end
        resp_rdy = 1'b1;
        @(posedge clk); #1;
        resp_rdy = 1'b0;
        chk("resp_done", 64'(resp_val), 64'd0);
        $display("op %s addr=%h data=%h exp=%h resp=%h", c ? (w ? "CAS" : "RD ") : (w ? "WR " : "RD "),
                 addr, data, exp, got);
    endtask

    task automatic run_op(input bit w, input bit c, input logic [63:0] addr, input logic [63:0] data,
                          input logic [63:0] exp, input int dly, output logic [63:0] got);
        logic [63:0] want;
        want = model_op(w, c, addr, data, exp);
        do_op(w, c, addr, data, exp, dly, got);
        if (!(w && !c)) chk("resp_data", got, want);
        chk("err", 64'(err), 64'(model_err));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] got;
        logic [63:0] a;
        int          idx;
        int          kind;

        rst_n    = 1'b0;
        req_val  = 1'b1;
        resp_rdy = 1'b0;
        scramble();
        #2;
        chk("rst_ack", 64'(req_ack), 64'd0);
        chk("rst_val", 64'(resp_val), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        req_val = 1'b0;
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill every word back-to-back with val held high.
        req_val = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            req_w    = 1'b1;
            req_c    = 1'b0;
            req_addr = BASE + 64'(8 * i) + 64'($urandom_range(0, 7));
            req_data = {$urandom, $urandom};
            void'(model_op(1'b1, 1'b0, req_addr, req_data, '0));
            @(negedge clk);
            chk("b2b_ack", 64'(req_ack), 64'd1);
            @(posedge clk); #1;
        end
        req_val = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = $urandom_range(0, DEPTH - 1);
            run_op(1'b0, 1'($urandom), BASE + 64'(8 * idx), '0, '0, 0, got);
        end

        // Write then read.
        run_op(1'b1, 1'b0, 64'h1008, 64'hDEAD_BEEF, '0, 0, got);
        run_op(1'b0, 1'b0, 64'h1008, '0, '0, 0, got);
        chk("rd_deadbeef", got, 64'hDEAD_BEEF);

        // CAS match then mismatch.
        run_op(1'b1, 1'b0, 64'h1010, 64'd5, '0, 0, got);
        run_op(1'b1, 1'b1, 64'h1010, 64'd9, 64'd5, 1, got);
        chk("cas_old5", got, 64'd5);
        run_op(1'b0, 1'b0, 64'h1010, '0, '0, 0, got);
        chk("cas_rd9", got, 64'd9);
        run_op(1'b1, 1'b1, 64'h1010, 64'd7, 64'd5, 2, got);
        chk("cas_old9", got, 64'd9);
        run_op(1'b0, 1'b0, 64'h1010, '0, '0, 0, got);
        chk("cas_keep9", got, 64'd9);

        // Backpressure: response held 10 cycles, a waiting request is not acked.
        req_w = 1'b0; req_c = 1'b0; req_addr = 64'h1008; req_val = 1'b1;
        #1;
        chk("bp_ack", 64'(req_ack), 64'd1);
        @(posedge clk); #1;
        req_val = 1'b0;
        @(posedge clk); #1;
        req_w = 1'b1; req_c = 1'b0; req_addr = 64'h1018; req_data = 64'h35; req_val = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_val", 64'(resp_val), 64'd1);
            chk("bp_data", resp_data, 64'hDEAD_BEEF);
            chk("bp_noack", 64'(req_ack), 64'd0);
            @(posedge clk); #1;
        end
        resp_rdy = 1'b1;
        #1;
        chk("bp_noack_hs", 64'(req_ack), 64'd0);
        @(posedge clk); #1;
        resp_rdy = 1'b0;
        #1;
        chk("bp_ack_after", 64'(req_ack), 64'd1);
        chk("bp_val_off", 64'(resp_val), 64'd0);
        @(posedge clk); #1;
        req_val = 1'b0;
        void'(model_op(1'b1, 1'b0, 64'h1018, 64'h35, '0));
        run_op(1'b0, 1'b0, 64'h1018, '0, '0, 0, got);

        // Reset in the CAS state with a matching expected value.
        req_w = 1'b1; req_c = 1'b1; req_addr = 64'h1010; req_data = 64'h55;
        req_exp = model_mem[2]; req_val = 1'b1;
        #1;
        chk("rc_ack", 64'(req_ack), 64'd1);
        @(posedge clk); #1;
        chk("rc_busy", 64'(resp_val), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("rc_val", 64'(resp_val), 64'd0);
        chk("rc_ack_rst", 64'(req_ack), 64'd0);
        chk("rc_err", 64'(err), 64'd0);
        req_val = 1'b0;
        #1;
        rst_n = 1'b1;
        model_err = 1'b0;
        @(posedge clk); #1;
        run_op(1'b0, 1'b0, 64'h1010, '0, '0, 0, got);
        chk("rc_unchanged", got, 64'd9);

        // Randomized mix.
        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 2);
            idx  = $urandom_range(0, DEPTH - 1);
            a    = BASE + 64'(8 * idx) + 64'($urandom_range(0, 7));
            run_op(kind != 0, kind == 2, a, {$urandom, $urandom},
                   ($urandom_range(0, 1) == 1) ? model_mem[idx] : {$urandom, $urandom},
                   $urandom_range(0, 3), got);
        end

        // One word past the end.
        run_op(1'b0, 1'b0, BASE + 64'(8 * DEPTH), '0, '0, 0, got);
`ifdef FALAFEL_MEM_BOUNDS_EN
        chk("oob_ones", got, '1);
        chk("oob_err", 64'(err), 64'd1);
        run_op(1'b0, 1'b0, 64'h1008, '0, '0, 0, got);
        chk("oob_err_sticky", 64'(err), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("oob_err_rst", 64'(err), 64'd0);
        rst_n = 1'b1;
        model_err = 1'b0;
        @(posedge clk); #1;
`else
        chk("wrap_word0", got, model_mem[0]);
        chk("wrap_err0", 64'(err), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
